// File: rtl/conv_mem_pkg.sv
// Shared definitions for the CONV layer memory: default widths, bank select codes
// and the comparator state encoding.
package conv_mem_pkg;

    localparam int DATA_W_DEF  = 20;
    localparam int ADDR_W_DEF  = 12;
    localparam int DEPTH_DEF   = 4096;
    localparam int N_BANKS_DEF = 5;
    localparam int SEL_W_DEF   = 3;
    localparam int ERR_W_DEF   = 16;

    // Code k selects bank k-1; SEL_NONE never addresses a bank.
    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_L0_K0 = 3'd1,
        SEL_L0_K1 = 3'd2,
        SEL_L1_K0 = 3'd3,
        SEL_L1_K1 = 3'd4,
        SEL_L2    = 3'd5
    } csel_e;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_RUN,
        CHK_DRAIN,
        CHK_DONE
    } chk_state_e;

endpackage

// File: rtl/conv_bank_sram.sv
// One write / one read synchronous bank. A read and a write to the same address in
// the same cycle return the word as it was before the write.
module conv_bank_sram
    import conv_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset so results survive a mid-check reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i[IW-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i[IW-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_layer_mem_checker.sv
// Multi-bank layer memory for CONV results with host read port and a streaming
// comparator that checks one bank against an external expected-data source.
module conv_layer_mem_checker
    import conv_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int N_BANKS = N_BANKS_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int ERR_W   = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cwr,
    input  logic [ADDR_W-1:0]  caddr_wr,
    input  logic [DATA_W-1:0]  cdata_wr,
    input  logic [SEL_W-1:0]   csel,
    input  logic               crd,
    input  logic [ADDR_W-1:0]  caddr_rd,
    output logic [DATA_W-1:0]  cdata_rd,
    output logic               rd_valid,
    output logic               sel_err,
    output logic [N_BANKS-1:0] bank_written,
    input  logic               chk_start,
    input  logic [SEL_W-1:0]   chk_bank,
    input  logic [ADDR_W:0]    chk_len,
    output logic [ADDR_W-1:0]  exp_addr,
    input  logic [DATA_W-1:0]  exp_data,
    output logic               chk_busy,
    output logic               chk_done,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr
);

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [SEL_W-1:0] NB_L    = SEL_W'(N_BANKS);

    function automatic logic selOk(input logic [SEL_W-1:0] s);
        return (s != SEL_W'(SEL_NONE)) && (s <= NB_L);
    endfunction

    chk_state_e        state_q, state_d;
    logic [SEL_W-1:0]  chkBank_q, chkBank_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] expAddr_q, expAddr_d;
    logic              cmpValid_q, cmpValid_d;
    logic [ADDR_W-1:0] cmpAddr_q, cmpAddr_d;
    logic [ERR_W-1:0]  errCount_q, errCount_d;
    logic [ADDR_W-1:0] firstErr_q, firstErr_d;

    logic               rdValid_q, rdOk_q, selErr_q;
    logic [SEL_W-1:0]   rdSel_q;
    logic [N_BANKS-1:0] bankWritten_q;

    logic cselOk, wrOk, rdOk, busy, hostRd, mismatch, lastIssue;
    logic [ADDR_W:0]    lenClamp;
    logic [N_BANKS-1:0] bankWe, bankRe;
    logic [ADDR_W-1:0]  bankRaddr;
    logic [DATA_W-1:0]  bankRdata [N_BANKS];
    logic [DATA_W-1:0]  hostData, cmpData;

    assign cselOk    = selOk(csel);
    assign wrOk      = cselOk && ({1'b0, caddr_wr} < DEPTH_L);
    assign rdOk      = cselOk && ({1'b0, caddr_rd} < DEPTH_L);
    assign busy      = (state_q == CHK_RUN) || (state_q == CHK_DRAIN);
    assign hostRd    = crd && !busy;
    assign lenClamp  = (chk_len > DEPTH_L) ? DEPTH_L : chk_len;
    assign lastIssue = ({1'b0, expAddr_q} == (len_q - (ADDR_W+1)'(1)));
    assign bankRaddr = busy ? expAddr_q : caddr_rd;

    // While the comparator is busy it owns every bank's read port.
    always_comb begin
        bankWe = '0;
        bankRe = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            bankWe[i] = cwr && wrOk && (csel == SEL_W'(i + 1));
            bankRe[i] = busy ? ((state_q == CHK_RUN) && (chkBank_q == SEL_W'(i + 1)))
                             : (crd && rdOk && (csel == SEL_W'(i + 1)));
        end
    end

    for (genvar g = 0; g < N_BANKS; g++) begin : gBank
        conv_bank_sram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) uBank (
            .clk_i   (clk),
            .we_i    (bankWe[g]),
            .waddr_i (caddr_wr),
            .wdata_i (cdata_wr),
            .re_i    (bankRe[g]),
            .raddr_i (bankRaddr),
            .rdata_o (bankRdata[g])
        );
    end

    always_comb begin
        hostData = '0;
        cmpData  = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            if (rdSel_q == SEL_W'(i + 1)) hostData = bankRdata[i];
            if (chkBank_q == SEL_W'(i + 1)) cmpData = bankRdata[i];
        end
    end

    assign mismatch = cmpValid_q && (cmpData != exp_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid_q     <= 1'b0;
            rdOk_q        <= 1'b0;
            rdSel_q       <= '0;
            selErr_q      <= 1'b0;
            bankWritten_q <= '0;
        end else begin
            rdValid_q     <= hostRd;
            rdOk_q        <= rdOk;
            rdSel_q       <= csel;
            selErr_q      <= (cwr && !wrOk) || (hostRd && !rdOk);
            bankWritten_q <= bankWritten_q | bankWe;
        end
    end

    // Bank data is one cycle behind exp_addr, matching the expected-data source, so
    // each compare happens the cycle after its address was issued.
    always_comb begin
        state_d    = state_q;
        chkBank_d  = chkBank_q;
        len_d      = len_q;
        expAddr_d  = expAddr_q;
        cmpValid_d = 1'b0;
        cmpAddr_d  = cmpAddr_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        if (mismatch) begin
            if (errCount_q == '0) firstErr_d = cmpAddr_q;
            if (errCount_q != '1) errCount_d = errCount_q + ERR_W'(1);
        end
        unique case (state_q)
            CHK_IDLE: begin
                if (chk_start) begin
                    chkBank_d  = chk_bank;
                    len_d      = lenClamp;
                    expAddr_d  = '0;
                    errCount_d = '0;
                    firstErr_d = '0;
                    state_d    = ((lenClamp == '0) || !selOk(chk_bank)) ? CHK_DONE : CHK_RUN;
                end
            end
            CHK_RUN: begin
                cmpValid_d = 1'b1;
                cmpAddr_d  = expAddr_q;
                if (lastIssue) state_d = CHK_DRAIN;
                else           expAddr_d = expAddr_q + ADDR_W'(1);
            end
            CHK_DRAIN: state_d = CHK_DONE;
            CHK_DONE:  state_d = CHK_IDLE;
            default:   state_d = CHK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CHK_IDLE;
            chkBank_q  <= '0;
            len_q      <= '0;
            expAddr_q  <= '0;
            cmpValid_q <= 1'b0;
            cmpAddr_q  <= '0;
            errCount_q <= '0;
            firstErr_q <= '0;
        end else begin
            state_q    <= state_d;
            chkBank_q  <= chkBank_d;
            len_q      <= len_d;
            expAddr_q  <= expAddr_d;
            cmpValid_q <= cmpValid_d;
            cmpAddr_q  <= cmpAddr_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
        end
    end

    assign cdata_rd       = (rdValid_q && rdOk_q) ? hostData : '0;
    assign rd_valid       = rdValid_q;
    assign sel_err        = selErr_q;
    assign bank_written   = bankWritten_q;
    assign exp_addr       = expAddr_q;
    assign chk_busy       = busy;
    assign chk_done       = (state_q == CHK_DONE);
    assign err_count      = errCount_q;
    assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_conv_layer_mem_checker.sv
// Scoreboard bench for conv_layer_mem_checker: stimulus pushes hand-computed
// expectations, a negedge monitor pops them whenever the DUT presents an output.
module tb_conv_layer_mem_checker;
    import conv_mem_pkg::*;

    localparam int DW = 20;
    localparam int AW = 12;
    localparam int EW = 4;
    localparam int NB = 5;

    logic          clk, reset;
    logic          cwr, crd, chk_start;
    logic [AW-1:0] caddr_wr, caddr_rd, exp_addr, first_err_addr;
    logic [DW-1:0] cdata_wr, cdata_rd, exp_data;
    logic [2:0]    csel, chk_bank;
    logic [AW:0]   chk_len;
    logic          rd_valid, sel_err, chk_busy, chk_done;
    logic [NB-1:0] bank_written;
    logic [EW-1:0] err_count;

    conv_layer_mem_checker #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .N_BANKS(NB), .SEL_W(3), .ERR_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .csel(csel), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .rd_valid(rd_valid), .sel_err(sel_err), .bank_written(bank_written),
        .chk_start(chk_start), .chk_bank(chk_bank), .chk_len(chk_len),
        .exp_addr(exp_addr), .exp_data(exp_data), .chk_busy(chk_busy),
        .chk_done(chk_done), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected-data ROM with one cycle of read latency.
    logic [DW-1:0] expRom [4096];
    always @(posedge clk) exp_data <= expRom[exp_addr];

    typedef struct { int cyc; logic [DW-1:0] data; } rdExp_t;
    typedef struct { int cyc; logic [EW-1:0] err; logic [AW-1:0] first; } chkExp_t;
    rdExp_t  rdQ[$];
    int      selQ[$];
    chkExp_t chkQ[$];
    rdExp_t  rdE;
    chkExp_t chkE;
    int      selE;

    int nCompared = 0;
    int nMismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every DUT output event must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid) begin
                if (rdQ.size() == 0) checkOutput("unexpected rd_valid", 32'd1, 32'd0);
                else begin
                    rdE = rdQ.pop_front();
                    checkOutput("rd_valid cycle", cyc, rdE.cyc);
                    checkOutput("cdata_rd", 32'(cdata_rd), 32'(rdE.data));
                end
            end
            if (sel_err) begin
                if (selQ.size() == 0) checkOutput("unexpected sel_err", 32'd1, 32'd0);
                else begin
                    selE = selQ.pop_front();
                    checkOutput("sel_err cycle", cyc, selE);
                end
            end
            if (chk_done) begin
                if (chkQ.size() == 0) checkOutput("unexpected chk_done", 32'd1, 32'd0);
                else begin
                    chkE = chkQ.pop_front();
                    checkOutput("chk_done cycle", cyc, chkE.cyc);
                    checkOutput("err_count", 32'(err_count), 32'(chkE.err));
                    checkOutput("first_err_addr", 32'(first_err_addr), 32'(chkE.first));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [2:0] sel, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra,
                                 input logic expRd, input logic [DW-1:0] expD, input logic expSel);
        rdExp_t t;
        cwr = w; csel = sel; caddr_wr = wa; cdata_wr = wd; crd = r; caddr_rd = ra;
        if (expRd) begin
            t.cyc = cyc + 1;
            t.data = expD;
            rdQ.push_back(t);
        end
        if (expSel) selQ.push_back(cyc + 1);
        tick();
        cwr = 1'b0;
        crd = 1'b0;
    endtask

    task automatic startCheck(input logic [2:0] bank, input int len, input int lat,
                              input logic [EW-1:0] err, input logic [AW-1:0] first);
        chkExp_t t;
        chk_bank = bank;
        chk_len = (AW+1)'(len);
        chk_start = 1'b1;
        t.cyc = cyc + lat;
        t.err = err;
        t.first = first;
        chkQ.push_back(t);
        tick();
        chk_start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && (rdQ.size() + selQ.size() + chkQ.size()) != 0; i++) tick();
        tick();
        checkOutput("queues drained", 32'(rdQ.size() + selQ.size() + chkQ.size()), 32'd0);
    endtask

    initial begin
        cwr = 0; crd = 0; csel = 0; caddr_wr = 0; caddr_rd = 0; cdata_wr = 0;
        chk_start = 0; chk_bank = 0; chk_len = 0;
        for (int i = 0; i < 4096; i++) expRom[i] = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset cdata_rd", 32'(cdata_rd), 32'd0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset sel_err", 32'(sel_err), 32'd0);
        checkOutput("reset bank_written", 32'(bank_written), 32'd0);
        checkOutput("reset exp_addr", 32'(exp_addr), 32'd0);
        checkOutput("reset chk_busy", 32'(chk_busy), 32'd0);
        checkOutput("reset chk_done", 32'(chk_done), 32'd0);
        checkOutput("reset err_count", 32'(err_count), 32'd0);
        checkOutput("reset first_err_addr", 32'(first_err_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Basic write then read, illegal selects, read-before-write.
        applyStimulus(1, SEL_L0_K0, 0, 20'h12345, 0, 0, 0, 0, 0);
        applyStimulus(0, SEL_L0_K0, 0, 0, 1, 0, 1, 20'h12345, 0);
        applyStimulus(1, SEL_NONE, 0, 20'hABCDE, 0, 0, 0, 0, 1);
        applyStimulus(1, 3'd7, 0, 20'hABCDE, 0, 0, 0, 0, 1);
        applyStimulus(0, 3'd6, 0, 0, 1, 0, 1, 20'h0, 1);
        applyStimulus(0, SEL_L0_K0, 0, 0, 1, 0, 1, 20'h12345, 0);
        applyStimulus(1, SEL_L0_K0, 0, 20'h55555, 1, 0, 1, 20'h12345, 0);
        applyStimulus(0, SEL_L0_K0, 0, 0, 1, 0, 1, 20'h55555, 0);
        waitDrain(10);
        checkOutput("bank_written after bank0", 32'(bank_written), 32'h01);

        // One mismatch at address 5 over eight words of bank 1.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, SEL_L0_K1, AW'(i), DW'(i), 0, 0, 0, 0, 0);
            expRom[i] = DW'(i);
        end
        expRom[5] = 20'hFFFFF;
        startCheck(SEL_L0_K1, 8, 10, 1, 5);
        waitDrain(40);
        checkOutput("bank_written after bank1", 32'(bank_written), 32'h03);

        // Host reads ignored while busy; a write during RUN is seen by the compare.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, SEL_L1_K0, AW'(i), DW'(100 + i), 0, 0, 0, 0, 0);
            expRom[i] = DW'(100 + i);
        end
        expRom[3] = 20'h00777;
        startCheck(SEL_L1_K0, 8, 10, 0, 0);
        applyStimulus(1, SEL_L1_K0, 3, 20'h00777, 1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, SEL_NONE, 0, 0, 1, 0, 0, 0, 0);
        waitDrain(40);

        // Twenty mismatches saturate a 4-bit counter; a second start while busy is ignored.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1, SEL_L1_K1, AW'(i), DW'(i), 0, 0, 0, 0, 0);
            expRom[i] = (i < 2) ? DW'(i) : (DW'(i) ^ 20'h80000);
        end
        startCheck(SEL_L1_K1, 22, 24, 15, 2);
        tick();
        chk_bank = SEL_L2; chk_len = '0; chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
        waitDrain(60);

        // Zero length and an illegal bank both finish the cycle after start with no errors.
        startCheck(SEL_L1_K1, 0, 1, 0, 0);
        waitDrain(10);
        startCheck(3'd6, 4, 1, 0, 0);
        waitDrain(10);

        // Reset in the middle of a check: busy drops at once, no done, data kept.
        chk_bank = SEL_L0_K1; chk_len = (AW+1)'(8); chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
        repeat (3) tick();
        checkOutput("chk_busy mid run", 32'(chk_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("chk_busy after reset", 32'(chk_busy), 32'd0);
        checkOutput("bank_written after reset", 32'(bank_written), 32'd0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        applyStimulus(0, SEL_L0_K1, 0, 0, 1, 5, 1, 20'h00005, 0);
        applyStimulus(0, SEL_L0_K0, 0, 0, 1, 0, 1, 20'h55555, 0);
        applyStimulus(0, SEL_L1_K0, 0, 0, 1, 3, 1, 20'h00777, 0);
        waitDrain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
